// File: rtl/hub75_framebuf.sv
// hub75_framebuf: frame buffer between a raster pixel stream and a HUB75 scan stage.
// Pixels arrive in raster order and are stored by segment (row band).
// The display side reads one word per segment, with a registered one-cycle latency.
// Optional macro HUB75_FB_DOUBLE_BUFFER_EN selects between two build modes:
//   defined   - two banks; the writer fills the back bank, then waits for i_frame_done
//               before the banks swap.
//   undefined - one bank; the writer overwrites the displayed memory directly.
module hub75_framebuf #(
    parameter int HPIXEL   = 64,
    parameter int VPIXEL   = 64,
    parameter int BPP      = 8,
    parameter int SEGMENTS = 2,
    localparam int ROWS    = VPIXEL / SEGMENTS,
    localparam int DEPTH   = ROWS * HPIXEL,
    localparam int ADDR_W  = $clog2(HPIXEL * VPIXEL)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_sof,
    input  logic [3*BPP-1:0]            s_data,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    output logic [SEGMENTS*3*BPP-1:0]   o_rd_data,
    input  logic                        i_frame_done,
    output logic                        o_frame_ready,
    output logic                        o_front_bank
);

    localparam int PIX_W = 3 * BPP;
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int MEM_W = $clog2(NBANK * DEPTH);
    localparam int COL_W = (HPIXEL > 1) ? $clog2(HPIXEL) : 1;
    localparam int ROW_W = (VPIXEL > 1) ? $clog2(VPIXEL) : 1;
    localparam int SEG_W = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;

    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             sof_seen_reg;
    logic             ready_reg;
    logic             frame_ready_reg;
    logic             front_bank;
    logic             back_bank;

    logic             accept;
    logic             wr_en;
    logic             last_px;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;
    logic [SEG_W-1:0] wr_seg;
    logic [MEM_W-1:0] wr_idx;
    logic [MEM_W-1:0] rd_idx;
    logic             rd_in_range;

    assign accept  = s_valid & s_ready;
    // Pixels before the first SOF after reset are dropped; the SOF pixel itself is written.
    assign wr_en   = accept & (s_sof | sof_seen_reg);
    assign last_px = wr_en && (wr_col == COL_W'(HPIXEL - 1)) && (wr_row == ROW_W'(VPIXEL - 1));
    assign rd_in_range = (int'(i_rd_addr) < DEPTH);

    // Write position (SOF forces 0,0) and bank-relative storage addresses.
    always_comb begin
        wr_col = s_sof ? '0 : col_reg;
        wr_row = s_sof ? '0 : row_reg;
        wr_seg = SEG_W'(int'(wr_row) / ROWS);
        wr_idx = MEM_W'(int'(back_bank) * DEPTH + (int'(wr_row) % ROWS) * HPIXEL + int'(wr_col));
        rd_idx = MEM_W'(int'(front_bank) * DEPTH + int'(i_rd_addr));
    end

    // Raster write counters, SOF tracking and input readiness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg      <= '0;
            row_reg      <= '0;
            sof_seen_reg <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            if (accept && s_sof) begin
                sof_seen_reg <= 1'b1;
            end
            if (wr_en) begin
                if (last_px) begin
                    col_reg <= '0;
                    row_reg <= '0;
                end else if (wr_col == COL_W'(HPIXEL - 1)) begin
                    col_reg <= '0;
                    row_reg <= wr_row + ROW_W'(1);
                end else begin
                    col_reg <= wr_col + COL_W'(1);
                    row_reg <= wr_row;
                end
            end
        end
    end

`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    logic front_bank_reg;

    // Back frame complete flag and bank swap on the display's end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready_reg <= 1'b0;
            front_bank_reg  <= 1'b0;
        end else if (frame_ready_reg && i_frame_done) begin
            frame_ready_reg <= 1'b0;
            front_bank_reg  <= ~front_bank_reg;
        end else if (last_px) begin
            frame_ready_reg <= 1'b1;
        end
    end

    assign front_bank = front_bank_reg;
    assign back_bank  = ~front_bank_reg;
    // A finished back frame stalls the writer until the swap.
    assign s_ready    = ready_reg & ~frame_ready_reg;
`else
    logic frame_done_unused;
    assign frame_done_unused = i_frame_done;

    // Single bank: frame-ready is a one-cycle pulse after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready_reg <= 1'b0;
        end else begin
            frame_ready_reg <= last_px;
        end
    end

    assign front_bank = 1'b0;
    assign back_bank  = 1'b0;
    assign s_ready    = ready_reg;
`endif

    assign o_frame_ready = frame_ready_reg;
    assign o_front_bank  = front_bank;

    // One memory per segment, holding every bank; the bank selects the upper address region.
    generate
        for (genvar gi = 0; gi < SEGMENTS; gi++) begin : g_seg
            logic [PIX_W-1:0] mem [NBANK*DEPTH];
            logic [PIX_W-1:0] rd_reg;

            // Write port: only the segment owning the current row takes the pixel.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_seg == SEG_W'(gi))) begin
                    mem[wr_idx] <= s_data;
                end
            end

            // Registered read from the front bank; out-of-range addresses read as zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_reg <= '0;
                end else if (rd_in_range) begin
                    rd_reg <= mem[rd_idx];
                end else begin
                    rd_reg <= '0;
                end
            end

            assign o_rd_data[gi*PIX_W +: PIX_W] = rd_reg;
        end
    endgenerate

endmodule
